// File: rtl/zx_vram_pkg.sv
// Shared types and sizes for the video-RAM port: RAM window, posted-write
// buffer depth, read FSM states and slot-owner encoding.
package zx_vram_pkg;

    localparam int VRAM_AW    = 13;
    localparam int WBUF_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DATA = 2'd2
    } rdState_t;

    typedef enum logic [1:0] {
        SLOT_VIDEO = 2'd0,
        SLOT_DRAIN = 2'd1,
        SLOT_READ  = 2'd2,
        SLOT_IDLE  = 2'd3
    } slotOwner_t;

    // Pointer width for a FIFO of the given depth; never narrower than one bit.
    function automatic int ptrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/vram_wbuf.sv
// Posted-write buffer: DEPTH-entry {addr,data} FIFO. A push while full and a
// pop while empty are ignored, so callers may assert them unconditionally.
module vram_wbuf
    import zx_vram_pkg::*;
#(
    parameter int AW    = VRAM_AW,
    parameter int DEPTH = WBUF_DEPTH,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [AW-1:0] pushAddr,
    input  logic [7:0]    pushData,
    input  logic          pop,
    output logic [AW-1:0] popAddr,
    output logic [7:0]    popData,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = ptrWidth(DEPTH);

    logic [AW-1:0] addrMem [DEPTH];
    logic [7:0]    dataMem [DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic          doPush;
    logic          doPop;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign doPush  = push & ~full;
    assign doPop   = pop & ~empty;
    assign popAddr = addrMem[rdPtr];
    assign popData = dataMem[rdPtr];

    // Entry storage; contents are meaningless once the pointers are reset.
    always_ff @(posedge clock) begin
        if (doPush) begin
            addrMem[wrPtr] <= pushAddr;
            dataMem[wrPtr] <= pushData;
        end
    end

    // Pointers and occupancy; push+pop together leaves the count unchanged.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= nextPtr(wrPtr);
            if (doPop)  rdPtr <= nextPtr(rdPtr);
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vram_port.sv
// Single-ported video-RAM controller. Video owns every ce slot it claims;
// free slots drain posted CPU writes first, then serve a pending CPU read.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no CPU read outstanding; writes are accepted here
// RD_WAIT | read pending, waiting for empty buffer and a non-video slot
// RD_DATA | read address issued; one RAM clock, then capture and cack
module vram_port
    import zx_vram_pkg::*;
#(
    parameter int AW    = VRAM_AW,
    parameter int DEPTH = WBUF_DEPTH
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ce,
    input  logic [AW-1:0] va,
    input  logic          vrd,
    output logic [7:0]    vd,
    input  logic [AW-1:0] ca,
    input  logic [7:0]    cdi,
    input  logic          creq,
    input  logic          cwr,
    output logic          cack,
    output logic [7:0]    cdo,
    output logic          cwait,
    output logic [AW-1:0] ma,
    output logic [7:0]    mdo,
    output logic          mwe,
    input  logic [7:0]    mdi
);

    localparam int CW = $clog2(DEPTH + 1);

    rdState_t      rdState;
    rdState_t      rdNext;
    slotOwner_t    slot;
    logic          wrAccept;
    logic          rdCapture;
    logic          rdLat;
    logic [1:0]    vidPipe;
    logic [AW-1:0] bufAddr;
    logic [7:0]    bufData;
    logic          bufFull;
    logic          bufEmpty;
    logic [CW-1:0] bufCount;

    vram_wbuf #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) uWbuf (
        .clock    (clock),
        .reset    (reset),
        .push     (wrAccept),
        .pushAddr (ca),
        .pushData (cdi),
        .pop      (slot == SLOT_DRAIN),
        .popAddr  (bufAddr),
        .popData  (bufData),
        .full     (bufFull),
        .empty    (bufEmpty),
        .count    (bufCount)
    );

    assign cwait = creq & ~cack;

    // Read FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rdState <= IDLE;
        else        rdState <= rdNext;
    end

    // Read FSM next state; a new request is only sampled while cack is low.
    always_comb begin
        rdNext = rdState;
        case (rdState)
            IDLE:    if (creq && !cwr && !cack) rdNext = RD_WAIT;
            RD_WAIT: if (slot == SLOT_READ)     rdNext = RD_DATA;
            RD_DATA: if (rdCapture)             rdNext = IDLE;
            default: rdNext = IDLE;
        endcase
    end

    // Slot arbitration and FSM-derived strobes. Fullness is the registered
    // count, so a same-clock drain does not make room for a push.
    always_comb begin
        slot = SLOT_IDLE;
        if (ce) begin
            if (vrd)                    slot = SLOT_VIDEO;
            else if (bufCount != '0)    slot = SLOT_DRAIN;
            else if (bufEmpty && rdState == RD_WAIT) slot = SLOT_READ;
        end
        wrAccept  = (rdState == IDLE) & creq & cwr & ~cack & ~bufFull;
        rdCapture = (rdState == RD_DATA) & ~rdLat;
    end

    // RAM port, video and CPU result registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ma      <= '0;
            mdo     <= '0;
            mwe     <= 1'b0;
            vd      <= '0;
            cdo     <= '0;
            cack    <= 1'b0;
            rdLat   <= 1'b0;
            vidPipe <= '0;
        end else begin
            mwe <= (slot == SLOT_DRAIN);
            case (slot)
                SLOT_VIDEO: ma <= va;
                SLOT_DRAIN: begin
                    ma  <= bufAddr;
                    mdo <= bufData;
                end
                SLOT_READ:  ma <= ca;
                default:    ;
            endcase
            // mdi answers one clock after ma, so capture two clocks after the slot.
            vidPipe <= {vidPipe[0], slot == SLOT_VIDEO};
            if (vidPipe[1]) vd <= mdi;
            rdLat <= (slot == SLOT_READ);
            if (rdCapture) cdo <= mdi;
            cack <= wrAccept | rdCapture;
        end
    end

endmodule

// File: tb/tb_vram_port.sv
// Directed bench for vram_port with a behavioural synchronous RAM and a
// commit log of every RAM write.
module tb_vram_port;
    import zx_vram_pkg::*;

    logic        clock;
    logic        reset;
    logic        ce;
    logic [12:0] va;
    logic        vrd;
    logic [7:0]  vd;
    logic [12:0] ca;
    logic [7:0]  cdi;
    logic        creq;
    logic        cwr;
    logic        cack;
    logic [7:0]  cdo;
    logic        cwait;
    logic [12:0] ma;
    logic [7:0]  mdo;
    logic        mwe;
    logic [7:0]  mdi;

    logic        preEn;
    logic [12:0] preAddr;
    logic [7:0]  preData;
    logic [7:0]  mem [0:8191];
    logic [12:0] cAddr [$];
    logic [7:0]  cData [$];

    int checks = 0;
    int errors = 0;
    int logSize;
    int mweSeen;

    vram_port dut (
        .clock (clock),
        .reset (reset),
        .ce    (ce),
        .va    (va),
        .vrd   (vrd),
        .vd    (vd),
        .ca    (ca),
        .cdi   (cdi),
        .creq  (creq),
        .cwr   (cwr),
        .cack  (cack),
        .cdo   (cdo),
        .cwait (cwait),
        .ma    (ma),
        .mdo   (mdo),
        .mwe   (mwe),
        .mdi   (mdi)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous RAM: data for ma appears on mdi one clock later.
    always @(posedge clock) begin
        if (preEn)    mem[preAddr] <= preData;
        else if (mwe) mem[ma] <= mdo;
        mdi <= mem[ma];
    end

    always @(posedge clock) begin
        if (mwe) begin
            cAddr.push_back(ma);
            cData.push_back(mdo);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [12:0] addr, input logic [7:0] data);
        preEn = 1'b1; preAddr = addr; preData = data;
        step();
        preEn = 1'b0;
    endtask

    initial begin
        reset = 1'b0; ce = 1'b0; va = '0; vrd = 1'b0; ca = '0; cdi = '0;
        creq = 1'b1; cwr = 1'b0; preEn = 1'b0; preAddr = '0; preData = '0;

        // Reset state
        repeat (3) step();
        check("rst_vd",   32'(vd),   32'h0);
        check("rst_cdo",  32'(cdo),  32'h0);
        check("rst_cack", 32'(cack), 32'h0);
        check("rst_ma",   32'(ma),   32'h0);
        check("rst_mdo",  32'(mdo),  32'h0);
        check("rst_mwe",  32'(mwe),  32'h0);
        check("rst_cwait_hi", 32'(cwait), 32'h1);
        creq = 1'b0;
        #1;
        check("rst_cwait_lo", 32'(cwait), 32'h0);
        reset = 1'b1;
        step();

        // Video read
        preload(13'h1800, 8'hA5);
        va = 13'h1800; vrd = 1'b1; ce = 1'b1;
        step();
        ce = 1'b0; vrd = 1'b0;
        check("vid_ma", 32'(ma), 32'h1800);
        check("vid_vd_1clk", 32'(vd), 32'h0);
        step();
        check("vid_vd_2clk_pre", 32'(vd), 32'h0);
        step();
        check("vid_vd", 32'(vd), 32'hA5);
        repeat (2) step();
        check("vid_vd_hold", 32'(vd), 32'hA5);

        // Posted writes under video contention
        ce = 1'b1; vrd = 1'b1;
        ca = 13'h0001; cdi = 8'h11; cwr = 1'b1; creq = 1'b1;
        step();
        check("wr1_cack", 32'(cack), 32'h1);
        creq = 1'b0;
        step();
        check("wr1_cack_drop", 32'(cack), 32'h0);
        ca = 13'h0002; cdi = 8'h22; creq = 1'b1;
        step();
        check("wr2_cack", 32'(cack), 32'h1);
        creq = 1'b0;
        step();
        ca = 13'h0003; cdi = 8'h33; creq = 1'b1;
        step();
        check("wr3_blocked", 32'(cack), 32'h0);
        repeat (3) step();
        check("wr3_cwait", 32'(cwait), 32'h1);
        check("full_count", 32'(dut.uWbuf.count), 32'h2);
        check("no_drain_video", 32'(mwe), 32'h0);
        vrd = 1'b0;
        step();
        check("drain1_mwe", 32'(mwe), 32'h1);
        check("drain1_ma", 32'(ma), 32'h0001);
        check("drain1_mdo", 32'(mdo), 32'h11);
        check("wr3_no_accept_on_pop", 32'(cack), 32'h0);
        step();
        check("wr3_cack", 32'(cack), 32'h1);
        check("drain2_ma", 32'(ma), 32'h0002);
        check("drain2_mdo", 32'(mdo), 32'h22);
        check("push_pop_count", 32'(dut.uWbuf.count), 32'h1);
        creq = 1'b0;
        step();
        check("drain3_ma", 32'(ma), 32'h0003);
        check("drain3_mdo", 32'(mdo), 32'h33);
        check("drain3_mwe", 32'(mwe), 32'h1);
        step();
        check("drain_done_mwe", 32'(mwe), 32'h0);
        check("commit_n", 32'(cAddr.size()), 32'h3);
        check("commit0_a", 32'(cAddr[0]), 32'h1);
        check("commit0_d", 32'(cData[0]), 32'h11);
        check("commit1_a", 32'(cAddr[1]), 32'h2);
        check("commit1_d", 32'(cData[1]), 32'h22);
        check("commit2_a", 32'(cAddr[2]), 32'h3);
        check("commit2_d", 32'(cData[2]), 32'h33);

        // Read after write
        ca = 13'h0100; cdi = 8'h5A; cwr = 1'b1; creq = 1'b1;
        step();
        check("raw_wr_cack", 32'(cack), 32'h1);
        cwr = 1'b0;
        step();
        check("raw_drain_mwe", 32'(mwe), 32'h1);
        check("raw_drain_ma", 32'(ma), 32'h0100);
        step();
        check("raw_state_wait", 32'(dut.rdState), 32'(RD_WAIT));
        check("raw_idle_mwe", 32'(mwe), 32'h0);
        step();
        check("raw_slot_ma", 32'(ma), 32'h0100);
        check("raw_slot_mwe", 32'(mwe), 32'h0);
        step();
        check("raw_cack_early", 32'(cack), 32'h0);
        step();
        check("raw_cack", 32'(cack), 32'h1);
        check("raw_cdo", 32'(cdo), 32'h5A);
        creq = 1'b0;
        step();
        check("raw_cack_pulse", 32'(cack), 32'h0);

        // Read blocked by video
        preload(13'h0200, 8'hC3);
        vrd = 1'b1; va = 13'h1800; ca = 13'h0200; cwr = 1'b0; creq = 1'b1;
        repeat (4) step();
        check("blk_state", 32'(dut.rdState), 32'(RD_WAIT));
        check("blk_cwait", 32'(cwait), 32'h1);
        check("blk_cack", 32'(cack), 32'h0);
        check("blk_ma_video", 32'(ma), 32'h1800);
        vrd = 1'b0;
        step();
        check("blk_slot_ma", 32'(ma), 32'h0200);
        check("blk_slot_mwe", 32'(mwe), 32'h0);
        step();
        check("blk_cack_early", 32'(cack), 32'h0);
        step();
        check("blk_cack", 32'(cack), 32'h1);
        check("blk_cdo", 32'(cdo), 32'hC3);
        creq = 1'b0;
        step();

        // Reset mid-drain
        vrd = 1'b1;
        ca = 13'h0401; cdi = 8'h77; cwr = 1'b1; creq = 1'b1;
        step();
        creq = 1'b0;
        step();
        ca = 13'h0402; cdi = 8'h88; creq = 1'b1;
        step();
        creq = 1'b0;
        step();
        check("mid_count", 32'(dut.uWbuf.count), 32'h2);
        logSize = cAddr.size();
        vrd = 1'b0;
        step();
        check("mid_drain_mwe", 32'(mwe), 32'h1);
        reset = 1'b0;
        #1;
        check("mid_rst_mwe",  32'(mwe),  32'h0);
        check("mid_rst_ma",   32'(ma),   32'h0);
        check("mid_rst_mdo",  32'(mdo),  32'h0);
        check("mid_rst_vd",   32'(vd),   32'h0);
        check("mid_rst_cdo",  32'(cdo),  32'h0);
        check("mid_rst_cack", 32'(cack), 32'h0);
        check("mid_rst_count", 32'(dut.uWbuf.count), 32'h0);
        repeat (2) step();
        reset = 1'b1;
        mweSeen = 0;
        repeat (20) begin
            step();
            if (mwe) mweSeen++;
        end
        check("post_rst_no_mwe", 32'(mweSeen), 32'h0);
        check("post_rst_no_commit", 32'(cAddr.size()), 32'(logSize));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
